max1000_top: RTL and testbench
==============================

# max1000_top

Board-level top for the MAX1000 (MAX10) target: a free-running counter selects entries of a fixed 16-entry LED pattern table, producing a "knight-rider" sweep on the eight user LEDs. It also drives diagnostic headers and an optional UART loopback on the FTDI bus. It sits directly on the device pins. In simulation, SHIFT=0 makes the pattern advance every clock.

## Interface
- SHIFT, default 0: counter bit used as the LSB of the 4-bit table address, i.e. the address advances every 2^SHIFT clocks. Legal range 0..28.

Ports:
- CLK12M  input  1  board clock (12 MHz on hardware); all logic on rising edge.
- USER_BTN  input  1  reset; asynchronous, active-low (button pressed = low = reset asserted).
- LED  output  8  pattern output, registered.
- PIO  output  8 (PIO[8:1])  PIO[4:1] = current table address, PIO[8:5] = 0.
- BDBUS  inout  6  BDBUS[0] = UART RX input from FTDI; BDBUS[1] = UART TX output; BDBUS[5:2] high-Z.
- D  output  15  D[14:0] = cnt[14:0], direct (combinational from the counter register).

## Operation
- cnt: 32-bit counter, reset 0, increments by 1 every clock while USER_BTN high; wraps 0xFFFFFFFF -> 0.
- addr = cnt[SHIFT+3:SHIFT] (4 bits, wraps 15 -> 0 naturally).
- Pattern table ROM (constant): entry i = 1<<i for i = 0..7; entry i = 1<<(15-i) for i = 8..15. Sequence: 01,02,04,08,10,20,40,80,80,40,20,10,08,04,02,01.
- LED register: reset 8'h00; each clock LED <= ROM[addr], with addr taken from the pre-increment cnt value.
- PIO[4:1] = addr (combinational from cnt); PIO[8:5] = 4'b0000.
- BDBUS[5:2] = 'z at all times; BDBUS[0] is never driven by this block.
- Reset values: cnt=0, LED=0x00, D=0, PIO=0, BDBUS[1]=1 (UART idle), loopback synchronizer flops = 1.
- Reset mid-operation: all registers return to reset values immediately on USER_BTN falling, independent of clock; counting resumes from 0 on the first rising edge with USER_BTN high.

## Timing
- Edge k after reset release (k = 1, 2, ...): cnt = k; LED = ROM[((k-1) >> SHIFT) mod 16].
- SHIFT=0: LED at edges 1..16 = 01,02,04,08,10,20,40,80,80,40,20,10,08,04,02,01; edge 17 = 01 (wrap).
- SHIFT=n: each LED value is held for 2^n consecutive clocks.
- LED latency: 1 clock from counter value to LED. D/PIO: 0 clocks (combinational from cnt).
- Loopback latency (when enabled): BDBUS[1] follows BDBUS[0] after 2 rising edges.

## Configuration
- TOP_UART_LOOPBACK_EN defined: BDBUS[0] passes through a 2-flop synchronizer (reset value 1) and drives BDBUS[1]; echoes the host serial line.
- TOP_UART_LOOPBACK_EN undefined: no synchronizer; BDBUS[1] is constant 1 (UART idle).

## Test plan
- Power-up reset: hold USER_BTN low 100 ns -> LED=0x00, D=0, PIO=0, BDBUS[1]=1.
- Sweep, SHIFT=0: release reset, sample LED on 16 edges -> 01,02,04,08,10,20,40,80,80,40,20,10,08,04,02,01; edge 17 -> 01; D equals edge count.
- Mid-run reset: pulse USER_BTN low for 20 ns after ~11 clocks -> LED/cnt drop to 0 asynchronously (before next edge); after release, first edge gives LED=0x01.
- SHIFT=2: each LED value is held 4 clocks; PIO[4:1] increments every 4 clocks; PIO[8:5]=0 throughout.
- Loopback: with TOP_UART_LOOPBACK_EN, BDBUS[0]=0 -> BDBUS[1]=0 after 2 edges, back to 1 two edges after BDBUS[0]=1. Without the macro, BDBUS[1] stays 1.
- Wrap: force cnt to 0xFFFFFFFE -> cnt 0xFFFFFFFF then 0x00000000; addr wraps 15->0; LED continues the table without glitching.

Source files
------------

// File: rtl/max1000_top.sv
// max1000_top: MAX1000 board top. A free-running counter walks a 16-entry
// knight-rider pattern table onto the user LEDs, exposes the counter and table
// address on the diagnostic headers, and optionally echoes the FTDI UART line.
// Optional feature macro: TOP_UART_LOOPBACK_EN (2-flop synchronized RX -> TX echo).
// SHIFT selects the counter bit used as the table address LSB (0..28).
module max1000_top #(
  parameter int SHIFT = 0
) (
  input  logic        CLK12M,
  input  logic        USER_BTN,
  output logic [7:0]  LED,
  output logic [8:1]  PIO,
  inout  wire  [5:0]  BDBUS,
  output logic [14:0] D
);

  logic [31:0] cnt;
  logic [3:0]  addr;
  logic [7:0]  rom_val;
  logic        uart_tx;

  // Table address is a 4-bit window of the counter; it wraps 15 -> 0 on its own.
  assign addr = cnt[SHIFT +: 4];

  // Free-running sweep counter, wraps naturally at 32 bits.
  always_ff @(posedge CLK12M or negedge USER_BTN) begin
    if (!USER_BTN) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  // Constant pattern table: light walks up bits 0..7, then back down 7..0.
  always_comb begin
    rom_val = 8'h00;
    case (addr)
      4'd0:  rom_val = 8'h01;
      4'd1:  rom_val = 8'h02;
      4'd2:  rom_val = 8'h04;
      4'd3:  rom_val = 8'h08;
      4'd4:  rom_val = 8'h10;
      4'd5:  rom_val = 8'h20;
      4'd6:  rom_val = 8'h40;
      4'd7:  rom_val = 8'h80;
      4'd8:  rom_val = 8'h80;
      4'd9:  rom_val = 8'h40;
      4'd10: rom_val = 8'h20;
      4'd11: rom_val = 8'h10;
      4'd12: rom_val = 8'h08;
      4'd13: rom_val = 8'h04;
      4'd14: rom_val = 8'h02;
      4'd15: rom_val = 8'h01;
      default: rom_val = 8'h00;
    endcase
  end

  // LED register samples the table entry addressed by the pre-increment count.
  always_ff @(posedge CLK12M or negedge USER_BTN) begin
    if (!USER_BTN) begin
      LED <= 8'h00;
    end else begin
      LED <= rom_val;
    end
  end

  assign D   = cnt[14:0];
  assign PIO = {4'b0000, addr};

`ifdef TOP_UART_LOOPBACK_EN
  logic rx_meta;
  logic rx_sync;

  // RX from the FTDI is asynchronous; two flops before echoing it back, idle high.
  always_ff @(posedge CLK12M or negedge USER_BTN) begin
    if (!USER_BTN) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= BDBUS[0];
      rx_sync <= rx_meta;
    end
  end

  assign uart_tx = rx_sync;
`else
  logic unused_rx;

  assign unused_rx = BDBUS[0];
  assign uart_tx   = 1'b1;
`endif

  // BDBUS[0] is the host's TX line; it is read but never driven from here.
  assign BDBUS[1]   = uart_tx;
  assign BDBUS[5:2] = 4'bzzzz;

endmodule

// File: tb/tb_max1000_top.sv
// Bench for max1000_top: two instances (SHIFT=0 and SHIFT=2) share clock and
// reset; a counter/table/queue model derives every expected value.
module tb_max1000_top;

  localparam int SH_A = 0;
  localparam int SH_B = 2;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [7:0]  led_a, led_b;
  logic [8:1]  pio_a, pio_b;
  logic [14:0] d_a, d_b;
  wire  [5:0]  bdbus_a, bdbus_b;

  assign bdbus_a[0] = rx;
  assign bdbus_b[0] = rx;

  int checks = 0;
  int errors = 0;

  logic [31:0] cnt_a, cnt_b;
  logic [7:0]  led_a_exp, led_b_exp;
  logic        rx_hist[$];

  max1000_top #(.SHIFT(SH_A)) dut_a (
    .CLK12M(clk), .USER_BTN(rst_n), .LED(led_a), .PIO(pio_a), .BDBUS(bdbus_a), .D(d_a)
  );

  max1000_top #(.SHIFT(SH_B)) dut_b (
    .CLK12M(clk), .USER_BTN(rst_n), .LED(led_b), .PIO(pio_b), .BDBUS(bdbus_b), .D(d_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_entry(int i);
    return (i < 8) ? 8'(1 << i) : 8'(1 << (15 - i));
  endfunction

  function automatic logic [3:0] addr_of(logic [31:0] c, int sh);
    return 4'((c >> sh) & 32'hF);
  endfunction

  function automatic logic tx_exp();
`ifdef TOP_UART_LOOPBACK_EN
    return rx_hist[0];
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    cnt_a = '0;
    cnt_b = '0;
    led_a_exp = 8'h00;
    led_b_exp = 8'h00;
    rx_hist = {1'b1, 1'b1};
  endtask

  // One rising edge of the model: LED takes the table entry of the old count.
  task automatic advance_model();
    led_a_exp = rom_entry(int'(addr_of(cnt_a, SH_A)));
    led_b_exp = rom_entry(int'(addr_of(cnt_b, SH_B)));
    cnt_a = cnt_a + 32'd1;
    cnt_b = cnt_b + 32'd1;
    rx_hist.push_back(rx);
    rx_hist.delete(0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    model_reset();
    #100;
    checks++; if (led_a !== 8'h00) begin errors++; $display("FAIL reset_led_a: got %02h expected 00", led_a); end
    checks++; if (led_b !== 8'h00) begin errors++; $display("FAIL reset_led_b: got %02h expected 00", led_b); end
    checks++; if (d_a !== 15'h0) begin errors++; $display("FAIL reset_d: got %04h expected 0000", d_a); end
    checks++; if (pio_a !== 8'h00) begin errors++; $display("FAIL reset_pio: got %02h expected 00", pio_a); end
    checks++; if (bdbus_a[1] !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", bdbus_a[1]); end
  endtask

  task automatic test_sweep();
    @(negedge clk); #2; rst_n = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      advance_model();
      checks++; if (led_a !== led_a_exp) begin errors++; $display("FAIL sweep_led edge %0d: got %02h expected %02h", e, led_a, led_a_exp); end
      checks++; if (d_a !== cnt_a[14:0]) begin errors++; $display("FAIL sweep_d edge %0d: got %04h expected %04h", e, d_a, cnt_a[14:0]); end
      checks++; if (pio_a !== {4'b0000, addr_of(cnt_a, SH_A)}) begin errors++; $display("FAIL sweep_pio edge %0d: got %02h expected %02h", e, pio_a, {4'b0000, addr_of(cnt_a, SH_A)}); end
      if (e == 17) begin
        checks++; if (led_a !== 8'h01) begin errors++; $display("FAIL sweep_wrap17: got %02h expected 01", led_a); end
      end
    end
  endtask

  task automatic test_shift2();
    int n = int'($urandom_range(60, 40));
    for (int e = 0; e < n; e++) begin
      @(posedge clk); #1;
      advance_model();
      checks++; if (led_b !== led_b_exp) begin errors++; $display("FAIL shift2_led step %0d: got %02h expected %02h", e, led_b, led_b_exp); end
      checks++; if (pio_b !== {4'b0000, addr_of(cnt_b, SH_B)}) begin errors++; $display("FAIL shift2_pio step %0d: got %02h expected %02h", e, pio_b, {4'b0000, addr_of(cnt_b, SH_B)}); end
      checks++; if (d_b !== cnt_b[14:0]) begin errors++; $display("FAIL shift2_d step %0d: got %04h expected %04h", e, d_b, cnt_b[14:0]); end
    end
  endtask

  task automatic test_mid_reset();
    int n = int'($urandom_range(14, 8));
    repeat (n) begin @(posedge clk); #1; advance_model(); end
    @(negedge clk); #2; rst_n = 1'b0; #1;
    model_reset();
    checks++; if (led_a !== 8'h00) begin errors++; $display("FAIL midrst_led_a: got %02h expected 00", led_a); end
    checks++; if (led_b !== 8'h00) begin errors++; $display("FAIL midrst_led_b: got %02h expected 00", led_b); end
    checks++; if (d_a !== 15'h0) begin errors++; $display("FAIL midrst_d: got %04h expected 0000", d_a); end
    checks++; if (pio_b !== 8'h00) begin errors++; $display("FAIL midrst_pio: got %02h expected 00", pio_b); end
    #19; rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      advance_model();
      checks++; if (led_a !== led_a_exp) begin errors++; $display("FAIL midrst_led edge %0d: got %02h expected %02h", e, led_a, led_a_exp); end
      checks++; if (d_a !== cnt_a[14:0]) begin errors++; $display("FAIL midrst_d edge %0d: got %04h expected %04h", e, d_a, cnt_a[14:0]); end
      if (e == 1) begin
        checks++; if (led_a !== 8'h01) begin errors++; $display("FAIL midrst_first: got %02h expected 01", led_a); end
      end
    end
  endtask

  task automatic test_loopback();
    for (int e = 0; e < 48; e++) begin
      @(negedge clk);
      if (e < 8) rx = (e < 4) ? 1'b0 : 1'b1;
      else       rx = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      advance_model();
      checks++; if (bdbus_a[1] !== tx_exp()) begin errors++; $display("FAIL loopback_tx step %0d: got %b expected %b", e, bdbus_a[1], tx_exp()); end
      checks++; if (bdbus_b[1] !== tx_exp()) begin errors++; $display("FAIL loopback_tx_b step %0d: got %b expected %b", e, bdbus_b[1], tx_exp()); end
    end
    @(negedge clk); rx = 1'b1;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut_a.cnt = 32'hFFFF_FFFE;
    #1;
    release dut_a.cnt;
    cnt_a = 32'hFFFF_FFFE;
    #1;
    checks++; if (d_a !== 15'h7FFE) begin errors++; $display("FAIL wrap_preload_d: got %04h expected 7ffe", d_a); end
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      advance_model();
      checks++; if (dut_a.cnt !== cnt_a) begin errors++; $display("FAIL wrap_cnt edge %0d: got %08h expected %08h", e, dut_a.cnt, cnt_a); end
      checks++; if (led_a !== led_a_exp) begin errors++; $display("FAIL wrap_led edge %0d: got %02h expected %02h", e, led_a, led_a_exp); end
      checks++; if (pio_a !== {4'b0000, addr_of(cnt_a, SH_A)}) begin errors++; $display("FAIL wrap_pio edge %0d: got %02h expected %02h", e, pio_a, {4'b0000, addr_of(cnt_a, SH_A)}); end
      checks++; if (d_a !== cnt_a[14:0]) begin errors++; $display("FAIL wrap_d edge %0d: got %04h expected %04h", e, d_a, cnt_a[14:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_shift2();
    test_mid_reset();
    test_loopback();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
